// File: rtl/cdr_pkg.sv
// Shared types and defaults for the clock/data-recovery phase detector.
package cdr_pkg;

   // Phase-detector FSM states; RST is the both-high anti-dead-zone window.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2,
      RST  = 2'd3
   } pfd_state_t;

   // Default tuning values.
   localparam int RST_DLY_DEF  = 2;
   localparam int ERR_W_DEF    = 8;
   localparam int LOCK_TOL_DEF = 2;
   localparam int LOCK_CNT_DEF = 16;

   // True when |v| <= tol.
   function automatic logic in_window(input int v, input int tol);
      return (v <= tol) && (v >= -tol);
   endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one async input.
// Edge detection is held off until the synchronizer and history flop have
// all been loaded from the live input, so an input already high at reset
// release is not reported as a rising edge.
module pfd_edge_sync
   import cdr_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   localparam int STAGES = 2;

   logic                s1, s2, s3;
   logic [STAGES:0]     vld_pipe;

   // Metastability flops, edge history and the fill tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         vld_pipe <= '0;
      end else begin
         s1       <= d;
         s2       <= s1;
         s3       <= s2;
         vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      end
   end

   // One-cycle pulse once s3 holds a genuine previous sample.
   assign rise = s2 & ~s3 & vld_pipe[STAGES];

endmodule

// File: rtl/pfd_digital.sv
// Digital phase/frequency detector: UP/DN/RST charge-pump FSM with a
// saturating signed phase counter, a lock qualifier and slip reporting.
module pfd_digital
   import cdr_pkg::*;
#(
   parameter int RST_DLY  = RST_DLY_DEF,
   parameter int ERR_W    = ERR_W_DEF,
   parameter int LOCK_TOL = LOCK_TOL_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ref_in,
   input  logic                    fb_in,
   output logic                    up,
   output logic                    down,
   output logic signed [ERR_W-1:0] phase_err,
   output logic                    err_valid,
   output logic                    locked,
   output logic                    slip
);

   localparam int RW = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam logic signed [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
   localparam logic signed [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};

   logic                    ref_rise, fb_rise;
   pfd_state_t              state, state_nxt;
   logic [RW-1:0]           rst_cnt;
   logic                    rst_done;
   logic signed [ERR_W-1:0] phase_cnt;
   logic signed [ERR_W-1:0] err_nxt;
   logic                    ev_nxt, slip_nxt;
   logic [LW-1:0]           lock_cnt, lock_nxt;
   int                      err_i;

   pfd_edge_sync u_ref_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ref_in),
      .rise  (ref_rise)
   );

   pfd_edge_sync u_fb_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fb_in),
      .rise  (fb_rise)
   );

   assign rst_done = (rst_cnt == RW'(RST_DLY - 1));

   // State register and RST dwell counter (zero on RST entry).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rst_cnt <= '0;
      end else begin
         state   <= state_nxt;
         rst_cnt <= (state == RST) ? rst_cnt + RW'(1) : '0;
      end
   end

   // Next state, phase report on RST entry, and slip on edges dropped in RST.
   always_comb begin
      state_nxt = state;
      err_nxt   = phase_err;
      ev_nxt    = 1'b0;
      slip_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (ref_rise && fb_rise) begin
               state_nxt = RST;
               err_nxt   = '0;
               ev_nxt    = 1'b1;
            end else if (ref_rise) begin
               state_nxt = UP;
            end else if (fb_rise) begin
               state_nxt = DN;
            end
         end
         UP: begin
            if (fb_rise) begin
               state_nxt = RST;
               err_nxt   = phase_cnt;
               ev_nxt    = 1'b1;
            end
         end
         DN: begin
            if (ref_rise) begin
               state_nxt = RST;
               err_nxt   = phase_cnt;
               ev_nxt    = 1'b1;
            end
         end
         RST: begin
            slip_nxt = ref_rise | fb_rise;
            if (rst_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Signed lead counter: seeded on UP/DN entry, saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_cnt <= '0;
      end else if (state == IDLE && state_nxt == UP) begin
         phase_cnt <= ERR_W'(1);
      end else if (state == IDLE && state_nxt == DN) begin
         phase_cnt <= '1;
      end else if (state == UP && state_nxt == UP) begin
         if (phase_cnt != ERR_MAX) phase_cnt <= phase_cnt + ERR_W'(1);
      end else if (state == DN && state_nxt == DN) begin
         if (phase_cnt != ERR_MIN) phase_cnt <= phase_cnt - ERR_W'(1);
      end
   end

   // Registered outputs decoded from next state so they move with the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up        <= 1'b0;
         down      <= 1'b0;
         phase_err <= '0;
         err_valid <= 1'b0;
         slip      <= 1'b0;
      end else begin
         up        <= (state_nxt == UP) || (state_nxt == RST);
         down      <= (state_nxt == DN) || (state_nxt == RST);
         phase_err <= err_nxt;
         err_valid <= ev_nxt;
         slip      <= slip_nxt;
      end
   end

   assign err_i = int'(phase_err);

   // Lock counter update on each reported comparison.
   always_comb begin
      lock_nxt = lock_cnt;
      if (err_valid) begin
         if (in_window(err_i, LOCK_TOL)) begin
            if (lock_cnt != LW'(LOCK_CNT)) lock_nxt = lock_cnt + LW'(1);
         end else begin
            lock_nxt = '0;
         end
      end
   end

   // Lock counter and indicator; an out-of-tolerance report drops locked next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         lock_cnt <= lock_nxt;
         locked   <= (lock_nxt == LW'(LOCK_CNT));
      end
   end

endmodule
